// File: rtl/write_resp_router.sv
// Write-response router: arbitrates slave B channels into one holding register and steers it to the master named in the BID prefix.
// Latency 1 cycle slave->master; full throughput while masters accept. Slaves are stalled (BREADY_S=0) while the hold is full and not draining.
// Optional macro WRESP_RR_EN selects round-robin arbitration instead of lowest-index-wins.
module write_resp_router #(
    parameter  int NUM_S     = 6,
    parameter  int NUM_M     = 3,
    parameter  int ID_BITS   = 4,
    parameter  int MSEL_BITS = 4,
    localparam int IDS_BITS  = ID_BITS + MSEL_BITS,
    localparam int SW        = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_S*IDS_BITS-1:0] BID_S,
    input  logic [NUM_S*2-1:0]        BRESP_S,
    input  logic [NUM_S-1:0]          BVALID_S,
    output logic [NUM_S-1:0]          BREADY_S,
    output logic [ID_BITS-1:0]        BID_M,
    output logic [1:0]                BRESP_M,
    output logic [NUM_M-1:0]          BVALID_M,
    input  logic [NUM_M-1:0]          BREADY_M,
    output logic                      decerr_drop
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_nxt;
    logic                   hold_vld;
    logic [ID_BITS-1:0]     hold_id;
    logic [1:0]             hold_resp;
    logic [MSEL_BITS-1:0]   hold_dst;

    logic [SW-1:0]          win;
    logic [IDS_BITS-1:0]    win_bid;
    logic [1:0]             win_resp;
    logic [MSEL_BITS-1:0]   win_dst;
    logic                   in_range;
    logic                   out_vld;
    logic                   m_hs;
    logic                   accept;

`ifdef WRESP_RR_EN
    logic [SW-1:0]          rr_ptr;
    logic [2*NUM_S-1:0]     rr_dbl;
    logic [NUM_S-1:0]       rr_rot;
    logic [SW-1:0]          rr_off;
    logic [SW:0]            rr_sum;

    // Rotate requests so the pointer position becomes bit 0, pick lowest, then rotate the index back.
    always_comb begin
        rr_dbl = {BVALID_S, BVALID_S} >> rr_ptr;
        rr_rot = rr_dbl[NUM_S-1:0];
        rr_off = '0;
        for (int i = NUM_S-1; i >= 0; i--) begin
            if (rr_rot[i]) rr_off = SW'(i);
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
        if (rr_sum >= (SW+1)'(NUM_S)) rr_sum = rr_sum - (SW+1)'(NUM_S);
        win = rr_sum[SW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (win == SW'(NUM_S-1)) ? '0 : win + 1'b1;
    end
`else
    always_comb begin
        win = '0;
        for (int i = NUM_S-1; i >= 0; i--) begin
            if (BVALID_S[i]) win = SW'(i);
        end
    end
`endif

    always_comb begin
        win_bid  = '0;
        win_resp = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (win == SW'(i)) begin
                win_bid  = BID_S[i*IDS_BITS +: IDS_BITS];
                win_resp = BRESP_S[i*2 +: 2];
            end
        end
        win_dst  = win_bid[IDS_BITS-1:ID_BITS];
        in_range = int'(win_dst) < NUM_M;
    end

    assign out_vld = (state == BUSY) && hold_vld;
    assign m_hs    = out_vld && |(BVALID_M & BREADY_M);
    // Reset gates accept so nothing is consumed from the slaves while rst is high.
    assign accept  = !rst && |BVALID_S && ((state == IDLE) || m_hs);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && in_range) state_nxt = BUSY;
            BUSY: if (m_hs) state_nxt = (accept && in_range) ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BREADY_S = '0;
        if (accept) BREADY_S[win] = 1'b1;
        for (int j = 0; j < NUM_M; j++) begin
            BVALID_M[j] = out_vld && (hold_dst == MSEL_BITS'(j));
        end
        BID_M   = out_vld ? hold_id   : '0;
        BRESP_M = out_vld ? hold_resp : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld    <= 1'b0;
            hold_id     <= '0;
            hold_resp   <= '0;
            hold_dst    <= '0;
            decerr_drop <= 1'b0;
        end else begin
            decerr_drop <= accept && !in_range;
            if (accept && in_range) begin
                hold_vld  <= 1'b1;
                hold_id   <= win_bid[ID_BITS-1:0];
                hold_resp <= win_resp;
                hold_dst  <= win_dst;
            end else if (m_hs) begin
                hold_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/write_resp_router.md
WRITE_RESP_ROUTER -- requirements
Module: write_resp_router

Interface
REQ-001 Parameter NUM_S, default 6, number of slave-side B channels.
REQ-002 Parameter NUM_M, default 3, number of master-side B channels.
REQ-003 Parameter ID_BITS, default 4, master-side BID width.
REQ-004 Parameter MSEL_BITS, default 4, width of the binary master-index field prepended to the ID on the slave side. Slave BID width is IDS_BITS = ID_BITS + MSEL_BITS.
REQ-005 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1, sole clock, rising edge.
REQ-007 Port rst, input, 1, synchronous active-high reset.
REQ-008 Port BID_S, input, NUM_S*IDS_BITS, slave i BID at slice i. Field [IDS_BITS-1:ID_BITS] holds the destination master index; [ID_BITS-1:0] holds the original ID.
REQ-009 Port BRESP_S, input, NUM_S*2, slave i BRESP at slice i.
REQ-010 Port BVALID_S, input, NUM_S, slave response valid.
REQ-011 Port BREADY_S, output, NUM_S, slave response accept.
REQ-012 Port BID_M, output, ID_BITS, shared BID to all masters.
REQ-013 Port BRESP_M, output, 2, shared BRESP to all masters.
REQ-014 Port BVALID_M, output, NUM_M, per-master valid; at most one bit set.
REQ-015 Port BREADY_M, input, NUM_M, per-master ready.
REQ-016 Port decerr_drop, output, 1, one-cycle pulse when a response with an out-of-range master index is discarded.

Function
REQ-017 The router SHALL contain one output holding register (hold_vld, hold_id, hold_resp, hold_dst) and a 2-state FSM: IDLE (hold empty) and BUSY (hold full).
REQ-018 Accept condition: accept = (IDLE, or BUSY with BVALID_M[hold_dst] & BREADY_M[hold_dst]) and |BVALID_S.
REQ-019 On accept, the router SHALL assert BREADY_S[w] for exactly the winner w in that same cycle, combinationally. All other BREADY_S bits SHALL be 0. When accept is false, all BREADY_S bits SHALL be 0.
REQ-020 On accept with a master index < NUM_M, the router SHALL load the hold register at the next edge and be in BUSY the next cycle. Slave-to-master latency is 1 cycle.
REQ-021 In BUSY, BVALID_M[hold_dst] SHALL be 1, BID_M = hold_id and BRESP_M = hold_resp. All other BVALID_M bits SHALL be 0.
REQ-022 In IDLE, BVALID_M SHALL be 0, BID_M SHALL be 0 and BRESP_M SHALL be 0.
REQ-023 BUSY is left only on the master handshake. If accept happens in the same cycle, the hold register reloads and the FSM stays BUSY, giving back-to-back throughput of 1 response/cycle. Otherwise the FSM returns to IDLE.
REQ-024 In BUSY, BID_M, BRESP_M and BVALID_M SHALL be stable until the master handshake, regardless of BVALID_S activity.
REQ-025 A winner whose master index is >= NUM_M SHALL still be accepted (BREADY_S pulsed). It is not loaded into the hold register, and decerr_drop pulses on the following cycle.
REQ-026 Default arbitration is fixed priority: lowest slave index wins.
REQ-027 Slave-side BREADY SHALL depend only on BVALID_S, the FSM state and the current master handshake; there SHALL be no combinational path from BVALID_S to BVALID_M.

Reset
REQ-028 While rst=1 at a rising edge, the FSM SHALL go to IDLE, hold_* SHALL clear to 0, decerr_drop SHALL go to 0, and the round-robin pointer (if present) SHALL go to 0.
REQ-029 While rst=1, BREADY_S SHALL be forced to 0 so that no slave response is consumed during reset.
REQ-030 Reset asserted in BUSY SHALL discard the held response without a master handshake.

Configuration
REQ-031 Macro WRESP_RR_EN defined: arbitration SHALL be round-robin. A pointer p (log2 NUM_S bits) is kept; search starts at p; on accept, p <= (w+1) mod NUM_S, wrapping at NUM_S-1 -> 0.
REQ-032 Macro WRESP_RR_EN undefined: fixed priority per REQ-026, with no pointer register.

Verification
REQ-033 Single response: BVALID_S[2]=1, BID_S[2]={4'd1,4'hA}, BRESP=2'b00, BREADY_M all 1 -> BREADY_S[2]=1 at cycle 0; BVALID_M=3'b010, BID_M=4'hA at cycle 1; IDLE at cycle 2.
REQ-034 Back-pressure: as REQ-033 with BREADY_M[1]=0 for 5 cycles -> BVALID_M[1] and BID_M held 5 cycles; all BREADY_S=0 during that window, even with BVALID_S[0]=1 pending.
REQ-035 Streaming: slaves 0 and 3 valid continuously, both targeting master 0, BREADY_M=1 -> one response per cycle after a 1-cycle fill. Fixed priority: slave 0 is always chosen. With WRESP_RR_EN: grants alternate 0,3,0,3.
REQ-036 Decode error: BID_S[4] master field = 4'd7 (NUM_M=3) -> BREADY_S[4]=1 for 1 cycle, decerr_drop=1 the next cycle, BVALID_M stays 0.
REQ-037 Mid-operation reset: rst=1 for one edge while in BUSY with BREADY_M=0 -> BVALID_M=0 the next cycle, FSM in IDLE, RR pointer = 0.
REQ-038 Round-robin wrap (WRESP_RR_EN, NUM_S=6): last grant was slave 5, slaves 0 and 5 both valid -> slave 0 is granted.
